// File: rtl/serial_sum_collector_if.sv
// Handshake and serial-adder signals between the sum collector and its environment.
// The slave side is the collector; the master side is the requester plus adder.
interface serial_sum_collector_if;
    logic       start;
    logic       sum_bit;
    logic       carry_bit;
    logic       load;
    logic       shift_en;
    logic       busy;
    logic [8:0] result;
    logic       result_valid;
    logic       result_ready;

    modport slave (
        input  start,
        input  sum_bit,
        input  carry_bit,
        input  result_ready,
        output load,
        output shift_en,
        output busy,
        output result,
        output result_valid
    );

    modport master (
        output start,
        output sum_bit,
        output carry_bit,
        output result_ready,
        input  load,
        input  shift_en,
        input  busy,
        input  result,
        input  result_valid
    );
endinterface

// File: rtl/serial_sum_collector.sv
// Serial sum collector: sequences an external bit-serial adder through one
// load strobe and eight shift cycles, assembles the 9-bit sum LSB first and
// hands it downstream over a valid/ready handshake.
module serial_sum_collector (
    input  logic                        clk,
    input  logic                        rst_n,
    serial_sum_collector_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] bit_cnt;
    logic [7:0] capture;
    logic [8:0] result_q;
    logic       result_valid_q;

    logic       last_bit;
    logic       handshake;

    assign last_bit  = (bit_cnt == 3'd7);
    assign handshake = result_valid_q && bus.result_ready;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create ordering-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; start is only looked at in IDLE, so it is never queued.
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = HOLD;
            HOLD:    if (handshake) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bit counter, capture shift register and result/valid registers.
    // NOTE: every datapath register here is reset, so an aborted operation
    // leaves no partial result visible after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt        <= 3'd0;
            capture        <= 8'd0;
            result_q       <= 9'd0;
            result_valid_q <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    bit_cnt <= 3'd0;
                end
                SHIFT: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    capture <= {bus.sum_bit, capture[7:1]};
                    // The last sum bit and the final carry are folded in on
                    // the same edge they arrive, not one cycle later.
                    if (last_bit) begin
                        result_q       <= {bus.carry_bit, bus.sum_bit, capture[7:1]};
                        result_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (handshake) result_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from state alone.
    assign bus.load         = (state == LOAD);
    assign bus.shift_en     = (state == SHIFT);
    assign bus.busy         = (state != IDLE);
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;

endmodule

// File: tb/tb_serial_sum_collector.sv
// Self-checking bench for serial_sum_collector: a behavioural serial adder
// feeds the DUT, expected sums (A+B) go into a scoreboard queue, and a
// monitor pops and compares on every result handshake.
module tb_serial_sum_collector;

    logic clk;
    logic rst_n;

    serial_sum_collector_if bus ();

    serial_sum_collector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural serial adder: latches operands on load, then presents one
    // sum bit and its carry-out per shift cycle, LSB first.
    logic [7:0] op_a, op_b;
    logic [7:0] add_a, add_b;
    logic [2:0] add_idx;
    logic       add_c;

    always @(posedge clk) begin
        if (bus.load) begin
            add_a   <= op_a;
            add_b   <= op_b;
            add_c   <= 1'b0;
            add_idx <= 3'd0;
        end else if (bus.shift_en) begin
            add_c   <= bus.carry_bit;
            add_idx <= add_idx + 3'd1;
        end
    end

    assign bus.sum_bit   = add_a[add_idx] ^ add_b[add_idx] ^ add_c;
    assign bus.carry_bit = (add_a[add_idx] & add_b[add_idx]) |
                           (add_c & (add_a[add_idx] ^ add_b[add_idx]));

    // Scoreboard: expected results in issue order.
    logic [8:0] exp_q[$];

    // Monitor: compare on every cycle where the handshake will complete.
    always @(negedge clk) begin
        if (rst_n && bus.result_valid && bus.result_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(bus.result_valid), 32'd0);
            end else begin
                check("result", 32'(bus.result), 32'(exp_q.pop_front()));
            end
        end
    end

    // One operation: hold_cycles of result_ready=0 after completion,
    // optional start re-pulse in SHIFT cycle 4, optional reset at SHIFT cycle rst_at.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input int hold_cycles, input bit repulse, input int rst_at);
        logic [8:0] exp;
        logic [8:0] held;
        int  n;
        int  loads;
        int  shifts;
        bit  busy_ok;
        bit  stable;
        bit  idle_ok;
        exp = {1'b0, a} + {1'b0, b};
        @(negedge clk);
        op_a = a;
        op_b = b;
        bus.result_ready = (hold_cycles == 0);
        bus.start = 1'b1;
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        bus.start = 1'b0;
        loads   = int'(bus.load);
        shifts  = int'(bus.shift_en);
        busy_ok = bus.busy;
        n = 0;
        while (!bus.result_valid && n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (rst_at != 0 && n == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_load",  32'(bus.load), 32'd0);
                check("rst_shift", 32'(bus.shift_en), 32'd0);
                check("rst_busy",  32'(bus.busy), 32'd0);
                check("rst_valid", 32'(bus.result_valid), 32'd0);
                check("rst_result", 32'(bus.result), 32'd0);
                void'(exp_q.pop_back());
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                idle_ok = 1'b1;
                repeat (12) begin
                    @(posedge clk);
                    #1;
                    idle_ok &= !bus.busy && !bus.result_valid;
                end
                check("rst_stays_idle", 32'(idle_ok), 32'd1);
                return;
            end
            bus.start = repulse && (n == 4);
            loads   += int'(bus.load);
            shifts  += int'(bus.shift_en);
            busy_ok &= bus.busy;
        end
        bus.start = 1'b0;
        check("latency", 32'(n), 32'd9);
        check("load_cycles", 32'(loads), 32'd1);
        check("shift_cycles", 32'(shifts), 32'd8);
        check("busy_during_op", 32'(busy_ok), 32'd1);
        if (hold_cycles > 0) begin
            held   = bus.result;
            stable = 1'b1;
            repeat (hold_cycles) begin
                @(posedge clk);
                #1;
                stable &= bus.result_valid && bus.busy && (bus.result == held);
            end
            check("hold_stable", 32'(stable), 32'd1);
            check("hold_value", 32'(held), 32'(exp));
            bus.result_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("post_hs_valid", 32'(bus.result_valid), 32'd0);
        check("post_hs_busy", 32'(bus.busy), 32'd0);
        check("post_hs_result_kept", 32'(bus.result), 32'(exp));
        if (repulse) begin
            idle_ok = 1'b1;
            repeat (12) begin
                @(posedge clk);
                #1;
                idle_ok &= !bus.busy;
            end
            check("repulse_ignored", 32'(idle_ok), 32'd1);
        end
    endtask

    task automatic run_back_to_back();
        int t;
        int last;
        int seen;
        int waited;
        op_a = 8'd17;
        op_b = 8'd250;
        repeat (3) exp_q.push_back(9'd267);
        @(negedge clk);
        bus.result_ready = 1'b1;
        bus.start = 1'b1;
        t = 0;
        last = 0;
        seen = 0;
        while (seen < 3 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
            if (bus.load) begin
                if (seen > 0) check("b2b_period", 32'(t - last), 32'd11);
                last = t;
                seen++;
            end
        end
        bus.start = 1'b0;
        check("b2b_loads", 32'(seen), 32'd3);
        waited = 0;
        while (bus.busy && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("b2b_drained", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.start        = 1'b1;
        bus.result_ready = 1'b0;
        op_a  = 8'd0;
        op_b  = 8'd0;
        rst_n = 1'b0;
        #1;
        check("reset_load", 32'(bus.load), 32'd0);
        check("reset_shift", 32'(bus.shift_en), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_valid", 32'(bus.result_valid), 32'd0);
        check("reset_result", 32'(bus.result), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("start_ignored_in_reset", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'd45,  8'd35,  0, 1'b0, 0);
        run_op(8'd90,  8'd110, 0, 1'b0, 0);
        run_op(8'd200, 8'd100, 0, 1'b0, 0);
        run_op(8'd45,  8'd35,  0, 1'b1, 0);
        run_op(8'd45,  8'd35,  5, 1'b0, 0);
        run_op(8'd45,  8'd35,  0, 1'b0, 5);
        run_op(8'd1,   8'd1,   0, 1'b0, 0);
        run_op(8'd255, 8'd255, 0, 1'b0, 0);
        run_op(8'd0,   8'd0,   1, 1'b0, 0);

        run_back_to_back();

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   int'($urandom_range(0, 3)), 1'b0, 0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
